// File: rtl/fb_swap_ctrl_if.sv
// Handshake/status bundle between the frame-buffer swap controller and its producer/display/AXI-select neighbours.
interface fb_swap_ctrl_if #(
    parameter int NUM_BUFS  = 2,
    parameter int DROP_BITS = 8
);
    localparam int BUF_BITS = $clog2(NUM_BUFS);

    logic                 swap_req;
    logic                 vsync;
    logic                 wr_issue;
    logic                 wr_done;
    logic [BUF_BITS-1:0]  prod_buf;
    logic [BUF_BITS-1:0]  cons_buf;
    logic                 prod_switch;
    logic                 cons_switch;
    logic                 prod_hold;
    logic                 busy;
    logic [DROP_BITS-1:0] dropped;
    logic                 err;

    modport master (
        output swap_req, vsync, wr_issue, wr_done,
        input  prod_buf, cons_buf, prod_switch, cons_switch, prod_hold, busy, dropped, err
    );

    modport slave (
        input  swap_req, vsync, wr_issue, wr_done,
        output prod_buf, cons_buf, prod_switch, cons_switch, prod_hold, busy, dropped, err
    );
endinterface

// File: rtl/fb_swap_ctrl.sv
// N-buffer framebuffer swap controller: drains in-flight writes, then commits (vsync-aligned in double mode).
// Latency: swap_req -> DRAIN >= DRAIN_MIN_CYCLES -> [vsync edge] -> COMMIT -> indices + pulses next cycle; prod_hold gates the producer.
module fb_swap_ctrl #(
    parameter int NUM_BUFS         = 2,
    parameter int OUTSTANDING_BITS = 4,
    parameter int DRAIN_MIN_CYCLES = 2,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int DROP_BITS        = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    fb_swap_ctrl_if.slave bus
);
    localparam int BUF_BITS = $clog2(NUM_BUFS);
    localparam bit MULTI    = (NUM_BUFS >= 3);
    localparam int DC_BITS  = $clog2(DRAIN_MIN_CYCLES + 1) + 1;
    localparam logic [OUTSTANDING_BITS-1:0] OUT_MAX  = '1;
    localparam logic [DROP_BITS-1:0]        DROP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WAIT_VSYNC,
        COMMIT
    } state_t;

    state_t                      state, state_nxt;
    logic [DC_BITS-1:0]          drain_cnt;
    logic [OUTSTANDING_BITS-1:0] out_cnt;
    logic                        vsync_prev;
    logic [BUF_BITS-1:0]         prod_buf_q, cons_buf_q, ready_buf_q;
    logic                        ready_valid_q;
    logic                        prod_switch_q, cons_switch_q;
    logic [DROP_BITS-1:0]        dropped_q;
    logic                        err_q;

    logic                        vsync_act, vsync_edge;
    logic                        issue_only, done_only, out_full, out_empty;
    logic                        cnt_ovf, cnt_unf, swap_busy_err, drain_met;
    logic [BUF_BITS-1:0]         prod_nxt, cons_nxt, ready_nxt;
    logic                        rvld_nxt, psw_nxt, csw_nxt, drop_inc;

    // Lowest buffer index owned by neither a nor b.
    function automatic logic [BUF_BITS-1:0] lowest_free(input logic [BUF_BITS-1:0] a,
                                                        input logic [BUF_BITS-1:0] b);
        logic [BUF_BITS-1:0] r;
        logic                found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (!found && (BUF_BITS'(i) != a) && (BUF_BITS'(i) != b)) begin
                r     = BUF_BITS'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign vsync_act  = VSYNC_ACTIVE_LOW ? ~bus.vsync : bus.vsync;
    assign vsync_edge = vsync_act & ~vsync_prev;

    assign issue_only    = bus.wr_issue & ~bus.wr_done;
    assign done_only     = bus.wr_done & ~bus.wr_issue;
    assign out_full      = (out_cnt == OUT_MAX);
    assign out_empty     = (out_cnt == '0);
    assign cnt_ovf       = issue_only & out_full;
    assign cnt_unf       = done_only & out_empty;
    assign swap_busy_err = bus.swap_req & (state != IDLE);
    assign drain_met     = (int'(drain_cnt) + 1) >= DRAIN_MIN_CYCLES;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.swap_req) state_nxt = DRAIN;
            DRAIN:      if (out_empty && drain_met) state_nxt = MULTI ? COMMIT : WAIT_VSYNC;
            WAIT_VSYNC: if (vsync_edge) state_nxt = COMMIT;
            COMMIT:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer ownership: the commit path wins over a plain present because a
    // coincident vsync edge hands the just-finished frame straight to display.
    always_comb begin
        prod_nxt  = prod_buf_q;
        cons_nxt  = cons_buf_q;
        ready_nxt = ready_buf_q;
        rvld_nxt  = ready_valid_q;
        psw_nxt   = 1'b0;
        csw_nxt   = 1'b0;
        drop_inc  = 1'b0;
        if (state == COMMIT) begin
            psw_nxt = 1'b1;
            if (!MULTI) begin
                prod_nxt = cons_buf_q;
                cons_nxt = prod_buf_q;
                csw_nxt  = 1'b1;
            end else begin
                drop_inc = ready_valid_q;
                if (vsync_edge) begin
                    cons_nxt = prod_buf_q;
                    rvld_nxt = 1'b0;
                    prod_nxt = lowest_free(prod_buf_q, prod_buf_q);
                    csw_nxt  = 1'b1;
                end else begin
                    ready_nxt = prod_buf_q;
                    rvld_nxt  = 1'b1;
                    prod_nxt  = lowest_free(cons_buf_q, prod_buf_q);
                end
            end
        end else if (MULTI && vsync_edge && ready_valid_q) begin
            cons_nxt = ready_buf_q;
            rvld_nxt = 1'b0;
            csw_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drain_cnt     <= '0;
            out_cnt       <= '0;
            vsync_prev    <= 1'b1;
            prod_buf_q    <= BUF_BITS'(1);
            cons_buf_q    <= '0;
            ready_buf_q   <= '0;
            ready_valid_q <= 1'b0;
            prod_switch_q <= 1'b0;
            cons_switch_q <= 1'b0;
            dropped_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            vsync_prev <= vsync_act;

            if (state == IDLE) begin
                drain_cnt <= '0;
            end else if (state == DRAIN && int'(drain_cnt) < DRAIN_MIN_CYCLES) begin
                drain_cnt <= drain_cnt + DC_BITS'(1);
            end

            if (issue_only && !out_full) begin
                out_cnt <= out_cnt + OUTSTANDING_BITS'(1);
            end else if (done_only && !out_empty) begin
                out_cnt <= out_cnt - OUTSTANDING_BITS'(1);
            end

            prod_buf_q    <= prod_nxt;
            cons_buf_q    <= cons_nxt;
            ready_buf_q   <= ready_nxt;
            ready_valid_q <= rvld_nxt;
            prod_switch_q <= psw_nxt;
            cons_switch_q <= csw_nxt;

            if (drop_inc && dropped_q != DROP_MAX) begin
                dropped_q <= dropped_q + DROP_BITS'(1);
            end

            if (cnt_ovf || cnt_unf || swap_busy_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.prod_buf    = prod_buf_q;
    assign bus.cons_buf    = cons_buf_q;
    assign bus.prod_switch = prod_switch_q;
    assign bus.cons_switch = cons_switch_q;
    assign bus.prod_hold   = bus.swap_req | (state != IDLE) | out_full;
    assign bus.busy        = (state != IDLE);
    assign bus.dropped     = dropped_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: double- and triple-buffer instances driven with identical stimulus, checked against a reference model.
module tb_fb_swap_ctrl;
    localparam int DMIN    = 2;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic reset_n;
    logic swap_req, vsync, wr_issue, wr_done;

    always #5 clk = ~clk;

    fb_swap_ctrl_if #(.NUM_BUFS(2), .DROP_BITS(8)) if2 ();
    fb_swap_ctrl_if #(.NUM_BUFS(3), .DROP_BITS(8)) if3 ();

    assign if2.swap_req = swap_req;
    assign if2.vsync    = vsync;
    assign if2.wr_issue = wr_issue;
    assign if2.wr_done  = wr_done;
    assign if3.swap_req = swap_req;
    assign if3.vsync    = vsync;
    assign if3.wr_issue = wr_issue;
    assign if3.wr_done  = wr_done;

    fb_swap_ctrl #(.NUM_BUFS(2), .OUTSTANDING_BITS(4), .DRAIN_MIN_CYCLES(DMIN),
                   .VSYNC_ACTIVE_LOW(1'b1), .DROP_BITS(8))
        dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    fb_swap_ctrl #(.NUM_BUFS(3), .OUTSTANDING_BITS(4), .DRAIN_MIN_CYCLES(DMIN),
                   .VSYNC_ACTIVE_LOW(1'b1), .DROP_BITS(8))
        dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

    int nvec = 0;
    int nmis = 0;

    // Reference model, index 0 = double-buffer instance, 1 = triple-buffer instance.
    int nb [2] = '{2, 3};
    int m_prod [2], m_cons [2], m_ready [2], m_cnt [2], m_drop [2], m_dcyc [2];
    bit m_rvld [2], m_psw [2], m_csw [2], m_err [2], m_vprev [2];
    bit m_drain [2], m_wait [2], m_commit [2];

    function automatic int lowest_not(int nbufs, int a, int b);
        for (int k = 0; k < nbufs; k++) if (k != a && k != b) return k;
        return 0;
    endfunction

    function automatic logic [31:0] pack(logic [3:0] p, logic [3:0] c, logic ps, logic cs,
                                         logic h, logic b, logic [7:0] dr, logic e);
        return {11'd0, p, c, ps, cs, h, b, dr, e};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_prod[d] = 1; m_cons[d] = 0; m_ready[d] = 0; m_rvld[d] = 0;
            m_psw[d] = 0; m_csw[d] = 0; m_cnt[d] = 0; m_err[d] = 0; m_drop[d] = 0;
            m_dcyc[d] = 0; m_vprev[d] = 1; m_drain[d] = 0; m_wait[d] = 0; m_commit[d] = 0;
        end
    endtask

    function automatic logic [31:0] model_view(int d, bit s);
        bit bsy;
        bsy = m_drain[d] | m_wait[d] | m_commit[d];
        return pack(4'(m_prod[d]), 4'(m_cons[d]), m_psw[d], m_csw[d],
                    s | bsy | (m_cnt[d] == CNT_MAX), bsy, 8'(m_drop[d]), m_err[d]);
    endfunction

    task automatic model_update(input bit s, input bit v, input bit i, input bit dn, input bit r);
        if (r) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit act, edg, bsy;
            int cnt0, oldp;
            act  = !v;
            edg  = act && !m_vprev[d];
            bsy  = m_drain[d] | m_wait[d] | m_commit[d];
            cnt0 = m_cnt[d];
            m_vprev[d] = act;
            m_psw[d]   = 0;
            m_csw[d]   = 0;
            if (i && !dn) begin
                if (cnt0 == CNT_MAX) m_err[d] = 1; else m_cnt[d] = cnt0 + 1;
            end else if (dn && !i) begin
                if (cnt0 == 0) m_err[d] = 1; else m_cnt[d] = cnt0 - 1;
            end
            if (s && bsy) m_err[d] = 1;
            if (m_commit[d]) begin
                m_commit[d] = 0;
                m_psw[d]    = 1;
                if (nb[d] == 2) begin
                    oldp = m_prod[d]; m_prod[d] = m_cons[d]; m_cons[d] = oldp; m_csw[d] = 1;
                end else begin
                    if (m_rvld[d] && m_drop[d] < 255) m_drop[d]++;
                    if (edg) begin
                        m_cons[d] = m_prod[d]; m_rvld[d] = 0; m_csw[d] = 1;
                        m_prod[d] = lowest_not(nb[d], m_cons[d], m_cons[d]);
                    end else begin
                        m_ready[d] = m_prod[d]; m_rvld[d] = 1;
                        m_prod[d]  = lowest_not(nb[d], m_cons[d], m_ready[d]);
                    end
                end
            end else begin
                if (nb[d] >= 3 && edg && m_rvld[d]) begin
                    m_cons[d] = m_ready[d]; m_rvld[d] = 0; m_csw[d] = 1;
                end
                if (m_wait[d]) begin
                    if (edg) begin m_wait[d] = 0; m_commit[d] = 1; end
                end else if (m_drain[d]) begin
                    m_dcyc[d]++;
                    if (cnt0 == 0 && m_dcyc[d] >= DMIN) begin
                        m_drain[d] = 0;
                        if (nb[d] == 2) m_wait[d] = 1; else m_commit[d] = 1;
                    end
                end else if (s) begin
                    m_drain[d] = 1; m_dcyc[d] = 0;
                end
            end
        end
    endtask

    // One clock: drive inputs mid-cycle, compare both DUTs with the model, advance the model.
    task automatic step(input bit s, input bit v, input bit i, input bit d, input bit r);
        @(negedge clk);
        swap_req = s; vsync = v; wr_issue = i; wr_done = d; reset_n = !r;
        #1;
        chk("model_dbl", pack(4'(if2.prod_buf), 4'(if2.cons_buf), if2.prod_switch, if2.cons_switch,
                              if2.prod_hold, if2.busy, if2.dropped, if2.err), model_view(0, s));
        chk("model_tri", pack(4'(if3.prod_buf), 4'(if3.cons_buf), if3.prod_switch, if3.cons_switch,
                              if3.prod_hold, if3.busy, if3.dropped, if3.err), model_view(1, s));
        model_update(s, v, i, d, r);
    endtask

    typedef struct {
        bit s; bit v; bit c;
        int prod; int cons; bit psw; bit csw; bit hold; bit busy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        bit vs;
        reset_n = 1'b0; swap_req = 1'b0; vsync = 1'b1; wr_issue = 1'b0; wr_done = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();

        // Double buffer, idle counter: swap at row 1, vsync edge at row 11, new indices at row 13.
        tbl[0]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
        tbl[13] = '{0, 1, 1, 0, 1, 1, 1, 0, 0};
        tbl[14] = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
        for (int k = 0; k < 15; k++) begin
            step(tbl[k].s, tbl[k].v, 0, 0, 0);
            if (tbl[k].c)
                chk($sformatf("tbl_row%0d", k),
                    pack(4'(if2.prod_buf), 4'(if2.cons_buf), if2.prod_switch, if2.cons_switch,
                         if2.prod_hold, if2.busy, 8'd0, 1'b0),
                    pack(4'(tbl[k].prod), 4'(tbl[k].cons), tbl[k].psw, tbl[k].csw,
                         tbl[k].hold, tbl[k].busy, 8'd0, 1'b0));
        end

        // Double buffer with outstanding writes: edge at 18 falls inside DRAIN and is ignored.
        for (int k = 0; k < 38; k++) begin
            step(k == 3, !(k == 18 || k == 19 || k == 33 || k == 34), k < 3,
                 k == 8 || k == 10 || k == 23, 0);
            if (k == 20) chk("drain_prod_held", 32'(if2.prod_buf), 32'd0);
            if (k == 20) chk("drain_busy", 32'(if2.busy), 32'd1);
            if (k == 24) chk("drain_busy_at_zero", 32'(if2.busy), 32'd1);
            if (k == 34) chk("drain_no_early_commit", 32'(if2.prod_buf), 32'd0);
            if (k == 35) chk("drain_commit", {30'd0, if2.prod_buf, if2.cons_buf}, 32'b10);
            if (k == 35) chk("drain_pulses", {30'd0, if2.prod_switch, if2.cons_switch}, 32'b11);
        end

        // Triple buffer: commit without vsync, then present on the next edge.
        step(0, 1, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            step(k == 0, !(k == 8 || k == 9), 0, 0, 0);
            if (k == 3) chk("tri_prod_before", 32'(if3.prod_buf), 32'd1);
            if (k == 4) chk("tri_prod_after", 32'(if3.prod_buf), 32'd2);
            if (k == 4) chk("tri_pulses_commit", {30'd0, if3.prod_switch, if3.cons_switch}, 32'b10);
            if (k == 9) chk("tri_present", {28'd0, 2'(if3.cons_buf), if3.cons_switch, if3.prod_switch}, 32'b0110);
        end

        // Triple buffer drop: two commits without an intervening vsync.
        for (int k = 0; k < 11; k++) begin
            step(k == 0 || k == 5, 1, 0, 0, 0);
            if (k == 4) chk("drop_first_prod", 32'(if3.prod_buf), 32'd0);
            if (k == 9) chk("drop_count", 32'(if3.dropped), 32'd1);
            if (k == 9) chk("drop_reuse_prod", 32'(if3.prod_buf), 32'd2);
            if (k == 9) chk("drop_prod_ne_cons", 32'(if3.prod_buf != if3.cons_buf), 32'd1);
        end

        // Swap request while busy.
        step(0, 1, 0, 0, 1);
        for (int k = 0; k < 13; k++) begin
            step(k == 0 || k == 1, 1, 0, 0, 0);
            if (k == 1) chk("busy_swap_err_pre", 32'(if3.err), 32'd0);
            if (k == 2) chk("busy_swap_err", 32'(if3.err), 32'd1);
            if (k == 12) chk("busy_swap_no_extra", {29'd0, if3.busy, 2'(if3.prod_buf)}, 32'd2);
        end

        // wr_done at zero count.
        step(0, 1, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step(k == 2, 1, 0, k == 0, 0);
            if (k == 0) chk("underflow_err_pre", 32'(if2.err), 32'd0);
            if (k == 1) chk("underflow_err", {30'd0, if2.err, if3.err}, 32'b11);
            if (k == 6) chk("underflow_count_held", {29'd0, if3.busy, 2'(if3.prod_buf)}, 32'd2);
        end

        // Reset in the middle of WAIT_VSYNC.
        step(0, 1, 0, 0, 1);
        for (int k = 0; k < 13; k++) begin
            step(k == 0, !(k == 8 || k == 9), 0, 0, k == 5);
            if (k == 4) chk("rst_wait_busy", 32'(if2.busy), 32'd1);
            if (k == 6) chk("rst_mid_swap", {29'd0, if2.busy, if2.prod_buf, if2.cons_buf}, 32'b010);
            if (k == 9 || k == 10)
                chk("rst_no_pulse", {28'd0, if2.prod_switch, if2.cons_switch, if2.prod_buf, if2.cons_buf}, 32'b0010);
        end

        // Randomised traffic, compared every cycle against the model.
        step(0, 1, 0, 0, 1);
        vs = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            bit s, i, d, r;
            if ($urandom % 6 == 0) vs = ~vs;
            s = ($urandom % 16 == 0);
            i = ($urandom % 3 == 0);
            if ((n % 700) < 60) d = 1'b0;
            else d = (m_cnt[0] > 0) ? ($urandom % 2 == 0) : ($urandom % 64 == 0);
            r = ($urandom % 500 == 0);
            step(s, vs, i, d, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
- Parametrised N-buffer frame-buffer swap controller: owns producer (gfx write) and consumer (display read) buffer indices for 2..4 SRAM framebuffers.
- Replaces the fixed 8-cycle switch hold with a real write-drain counter and vsync-aligned commit.
- Adds triple/quad-buffer mode, where the producer never waits for vsync.
- Sits between the gfx/fb_writer path, the pixel stream's vsync and the multi-SRAM AXI controller's buffer select.

Parameters:
- NUM_BUFS, 2, number of framebuffers (2..4); 2 = double-buffer mode, >=3 = multi-buffer mode.
- OUTSTANDING_BITS, 4, width of the in-flight write counter; max outstanding = 2^OUTSTANDING_BITS-1.
- DRAIN_MIN_CYCLES, 2, minimum cycles spent in DRAIN (covers controller pipeline).
- VSYNC_ACTIVE_LOW, 1, vsync polarity; commit edge = transition into the active level.
- DROP_BITS, 8, width of the dropped-frame counter.
- BUF_BITS (localparam), $clog2(NUM_BUFS), buffer index width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- swap_req  in  1  one-cycle pulse: producer finished a frame.
- vsync  in  1  display vsync, clk domain.
- wr_issue  in  1  producer AW handshake (awvalid&&awready).
- wr_done  in  1  producer B handshake (bvalid&&bready).
- prod_buf  out  BUF_BITS  buffer the producer writes.
- cons_buf  out  BUF_BITS  buffer the consumer reads.
- prod_switch  out  1  pulse: prod_buf changed this cycle.
- cons_switch  out  1  pulse: cons_buf changed this cycle.
- prod_hold  out  1  producer must not issue writes (gate gfx_ready).
- busy  out  1  swap in progress (state != IDLE).
- dropped  out  DROP_BITS  saturating count of completed frames never displayed.
- err  out  1  sticky: wr_done at zero count, wr_issue at max count, or swap_req while busy.

Behaviour:
- Reset values (reset_n low at posedge):
  - prod_buf=1, cons_buf=0, ready_valid=0.
  - prod_switch=0, cons_switch=0, busy=0, dropped=0, err=0.
  - Outstanding count=0, state=IDLE.
  - Reset mid-swap aborts the swap; no pulses are emitted.
- Outstanding counter:
  - +1 on wr_issue, -1 on wr_done; both in the same cycle = no change.
  - wr_issue at max: counter holds, err set.
  - wr_done at 0: counter holds, err set.
- prod_hold (combinational) = swap_req | (state!=IDLE) | (count==max).
- vsync edge: registered previous sample. The edge is the first cycle vsync is at its active level.
- FSM states: IDLE, DRAIN, WAIT_VSYNC, COMMIT.
  - IDLE: swap_req -> DRAIN; drain cycle counter cleared.
  - DRAIN: leave when count==0 AND at least DRAIN_MIN_CYCLES spent in DRAIN. Exits to WAIT_VSYNC if NUM_BUFS==2, otherwise to COMMIT.
  - WAIT_VSYNC (double only): on vsync edge -> COMMIT. An edge occurring during DRAIN is not remembered.
  - COMMIT: one cycle. Indices update at the end of COMMIT; return to IDLE.
- Double-buffer commit:
  - prod_buf and cons_buf swap.
  - prod_switch=cons_switch=1 for exactly the first cycle the new values are visible.
- Multi-buffer commit:
  - The finished prod_buf becomes ready_buf.
  - If ready_valid was already 1, the old ready buffer is freed and dropped increments.
  - New prod_buf = lowest index not in {cons_buf, new ready_buf}; prod_switch pulses.
- Multi-buffer present:
  - On any vsync edge with ready_valid=1 (independent of FSM): cons_buf<=ready_buf, ready_valid<=0, cons_switch pulses.
  - No ready frame at vsync: cons_buf unchanged, no pulse.
- Simultaneous COMMIT and vsync edge (multi-buffer):
  - The newly finished buffer goes directly to cons_buf; ready_valid=0.
  - A previously ready frame counts as dropped.
  - New prod_buf = lowest index != new cons_buf.
  - Both pulses fire.
- swap_req while busy: ignored, err set.
- dropped saturates at all-ones.
- Invariants: prod_buf != cons_buf always; ready_buf distinct from both when valid.

Test Plan:
- Double, idle counter: swap_req at T, DRAIN_MIN=2, vsync edge at T+10 -> commit in cycle T+11; at T+12 prod_buf=0, cons_buf=1, both pulses for 1 cycle; prod_hold high T..T+11.
- Double, drain: 3 wr_issue then swap_req, wr_done at T+5,T+7,T+20 -> stays in DRAIN until the count hits 0 at T+20; a vsync edge at T+15 is ignored; commit only on the next edge.
- Triple: swap_req with count 0 -> prod_buf 1->2 after DRAIN+COMMIT, no vsync needed; next vsync edge -> cons_buf=1, cons_switch=1.
- Triple, drop: two swap_reqs with no vsync between -> second commit: dropped=1, prod_buf reuses the freed index, prod_buf != cons_buf.
- Errors: wr_done at count 0 -> err=1, count stays 0; swap_req while busy -> err=1, no extra commit.
- Reset mid-WAIT_VSYNC: reset_n low 1 cycle -> prod_buf=1, cons_buf=0, busy=0, no pulses on the following vsync edge.
